usb_host_presence_monitor: RTL and testbench

Supervises the full-speed bus for the DFU core. Inputs are the raw USB receive lines and the SOF stream from usb_fs_pe. It reports host presence, USB suspend/resume, bus reset, and SOF-continuity faults. It replaces the fixed-constant presence timer that is currently commented out of the core, with every threshold parametrised and bus-state detection added.

---
 rtl/usb_host_presence_monitor_if.sv | 38 +++
 rtl/usb_host_presence_monitor.sv | 189 ++++++++++++++++++
 tb/tb_usb_host_presence_monitor.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_host_presence_monitor_if.sv
// Bus-side signals of usb_host_presence_monitor.
//   master : drives the raw receive lines, tx enable and the SOF stream; observes status.
//   slave  : the monitor itself; consumes line/SOF inputs and drives the status outputs.
// Signals:
//   usb_p_rx, usb_n_rx : raw D+/D- receive (D+ forced to J while transmitting)
//   usb_tx_en          : device is transmitting
//   sof_valid          : one-cycle SOF strobe, frame_index valid with it
//   host_present, host_timeout, suspended, resume, bus_reset, sof_missed, frame_skip,
//   fault_count        : supervision outputs
interface usb_host_presence_monitor_if #(
  parameter int unsigned SKIP_CNT_W = 8
);
  logic                  usb_p_rx;
  logic                  usb_n_rx;
  logic                  usb_tx_en;
  logic                  sof_valid;
  logic [10:0]           frame_index;
  logic                  host_present;
  logic                  host_timeout;
  logic                  suspended;
  logic                  resume;
  logic                  bus_reset;
  logic                  sof_missed;
  logic                  frame_skip;
  logic [SKIP_CNT_W-1:0] fault_count;

  modport master (
    output usb_p_rx, usb_n_rx, usb_tx_en, sof_valid, frame_index,
    input  host_present, host_timeout, suspended, resume, bus_reset, sof_missed,
           frame_skip, fault_count
  );

  modport slave (
    input  usb_p_rx, usb_n_rx, usb_tx_en, sof_valid, frame_index,
    output host_present, host_timeout, suspended, resume, bus_reset, sof_missed,
           frame_skip, fault_count
  );
endinterface

// File: rtl/usb_host_presence_monitor.sv
// Full-speed bus supervisor for the DFU core.
// Watches the raw receive lines and the SOF stream and reports host presence, suspend/resume,
// bus reset and SOF-continuity faults.
// Ports:
//   clk_48mhz : system clock
//   reset     : asynchronous, active-low reset
//   bus       : usb_host_presence_monitor_if.slave (line inputs, SOF stream, status outputs)
module usb_host_presence_monitor #(
  parameter int unsigned PRESENCE_TIMEOUT_CYCLES = 48000000,
  parameter int unsigned SUSPEND_CYCLES          = 144000,
  parameter int unsigned BUS_RESET_CYCLES        = 120,
  parameter int unsigned FRAME_CYCLES            = 48000,
  parameter int unsigned SOF_SLACK_CYCLES        = 480,
  parameter int unsigned SKIP_CNT_W              = 8
) (
  input logic                        clk_48mhz,
  input logic                        reset,
  usb_host_presence_monitor_if.slave bus
);

  localparam int unsigned PresW = $clog2(PRESENCE_TIMEOUT_CYCLES + 1);
  localparam int unsigned IdleW = $clog2(SUSPEND_CYCLES + 1);
  localparam int unsigned Se0W  = $clog2(BUS_RESET_CYCLES + 1);
  localparam int unsigned WinW  = $clog2(FRAME_CYCLES + SOF_SLACK_CYCLES + 1);

  localparam logic [PresW-1:0] PresMax   = PresW'(PRESENCE_TIMEOUT_CYCLES);
  localparam logic [IdleW-1:0] IdleMax   = IdleW'(SUSPEND_CYCLES);
  localparam logic [Se0W-1:0]  Se0Max    = Se0W'(BUS_RESET_CYCLES);
  localparam logic [WinW-1:0]  WinLimit  = WinW'(FRAME_CYCLES + SOF_SLACK_CYCLES);
  localparam logic [WinW-1:0]  WinReload = WinW'(SOF_SLACK_CYCLES);

  typedef enum logic [0:0] {StAwake, StSuspend} susp_state_e;

  susp_state_e state_q, state_d;

  logic                  p_meta_q, p_sync_q, n_meta_q, n_sync_q;
  logic [Se0W-1:0]       se0_cnt_q, se0_cnt_d;
  logic [IdleW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [PresW-1:0]      pres_cnt_q, pres_cnt_d;
  logic [WinW-1:0]       win_cnt_q, win_cnt_d;
  logic                  host_present_q, host_present_d;
  logic                  host_timeout_q, host_timeout_d;
  logic                  resume_q, resume_d;
  logic                  sof_missed_q, sof_missed_d;
  logic                  frame_skip_q, frame_skip_d;
  logic [SKIP_CNT_W-1:0] fault_q, fault_d;
  logic [10:0]           prev_index_q, prev_index_d;
  logic                  have_prev_q, have_prev_d;

  logic        line_j, line_se0, bus_reset_w, suspend_entry;
  logic [WinW-1:0] win_inc;
  logic [10:0] expected_index;

  assign line_j      = p_sync_q & ~n_sync_q;
  assign line_se0    = ~p_sync_q & ~n_sync_q;
  assign bus_reset_w = (se0_cnt_q == Se0Max);

  // Line-state counters.
  always_comb begin
    se0_cnt_d = '0;
    if (line_se0 && !bus.usb_tx_en) begin
      se0_cnt_d = (se0_cnt_q == Se0Max) ? se0_cnt_q : se0_cnt_q + 1'b1;
    end
    idle_cnt_d = '0;
    if (line_j && !bus.usb_tx_en && !bus.sof_valid) begin
      idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end
  end

  // Suspend FSM.
  always_comb begin
    state_d       = state_q;
    resume_d      = 1'b0;
    suspend_entry = 1'b0;
    unique case (state_q)
      StAwake: begin
        if (idle_cnt_d == IdleMax) begin
          state_d       = StSuspend;
          suspend_entry = 1'b1;
        end
      end
      StSuspend: begin
        if (!line_j || bus_reset_w) begin
          state_d  = StAwake;
          resume_d = 1'b1;
        end
      end
      default: state_d = StAwake;
    endcase
  end

  // Presence, SOF window, frame continuity and fault counting.
  always_comb begin
    pres_cnt_d = (pres_cnt_q == PresMax) ? pres_cnt_q : pres_cnt_q + 1'b1;
    if (bus.sof_valid || bus_reset_w) begin
      pres_cnt_d = '0;
    end
    // sof_valid and bus_reset force the timer to 0, so a coincident SOF never times out.
    host_timeout_d = host_present_q && (pres_cnt_d == PresMax);

    host_present_d = host_present_q;
    if (bus_reset_w) begin
      host_present_d = 1'b0;
    end else if (bus.sof_valid) begin
      host_present_d = 1'b1;
    end else if (host_timeout_d) begin
      host_present_d = 1'b0;
    end

    // The window keeps running while gated so its phase stays tied to the last SOF.
    win_inc      = win_cnt_q + 1'b1;
    win_cnt_d    = win_inc;
    sof_missed_d = 1'b0;
    if (bus.sof_valid) begin
      win_cnt_d = '0;
    end else if (win_inc == WinLimit) begin
      win_cnt_d    = WinReload;
      sof_missed_d = host_present_q && (state_q == StAwake);
    end

    expected_index = prev_index_q + 11'd1;
    frame_skip_d   = bus.sof_valid && have_prev_q && (bus.frame_index != expected_index);
    prev_index_d   = bus.sof_valid ? bus.frame_index : prev_index_q;

    have_prev_d = have_prev_q;
    if (bus_reset_w || suspend_entry || host_timeout_d) begin
      have_prev_d = 1'b0;
    end else if (bus.sof_valid) begin
      have_prev_d = 1'b1;
    end

    fault_d = fault_q;
    if (bus_reset_w) begin
      fault_d = '0;
    end else if ((sof_missed_d || frame_skip_d) && (fault_q != {SKIP_CNT_W{1'b1}})) begin
      fault_d = fault_q + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      p_meta_q       <= 1'b1;
      p_sync_q       <= 1'b1;
      n_meta_q       <= 1'b0;
      n_sync_q       <= 1'b0;
      se0_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      pres_cnt_q     <= '0;
      win_cnt_q      <= '0;
      state_q        <= StAwake;
      host_present_q <= 1'b0;
      host_timeout_q <= 1'b0;
      resume_q       <= 1'b0;
      sof_missed_q   <= 1'b0;
      frame_skip_q   <= 1'b0;
      fault_q        <= '0;
      prev_index_q   <= '0;
      have_prev_q    <= 1'b0;
    end else begin
      p_meta_q       <= bus.usb_p_rx;
      p_sync_q       <= p_meta_q;
      n_meta_q       <= bus.usb_n_rx;
      n_sync_q       <= n_meta_q;
      se0_cnt_q      <= se0_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      pres_cnt_q     <= pres_cnt_d;
      win_cnt_q      <= win_cnt_d;
      state_q        <= state_d;
      host_present_q <= host_present_d;
      host_timeout_q <= host_timeout_d;
      resume_q       <= resume_d;
      sof_missed_q   <= sof_missed_d;
      frame_skip_q   <= frame_skip_d;
      fault_q        <= fault_d;
      prev_index_q   <= prev_index_d;
      have_prev_q    <= have_prev_d;
    end
  end

  assign bus.host_present = host_present_q;
  assign bus.host_timeout = host_timeout_q;
  assign bus.suspended    = (state_q == StSuspend);
  assign bus.resume       = resume_q;
  assign bus.bus_reset    = bus_reset_w;
  assign bus.sof_missed   = sof_missed_q;
  assign bus.frame_skip   = frame_skip_q;
  assign bus.fault_count  = fault_q;

endmodule

// File: tb/tb_usb_host_presence_monitor.sv
// Self-checking bench for usb_host_presence_monitor with small thresholds.
module tb_usb_host_presence_monitor;

  localparam int PRES  = 200;
  localparam int SUSP  = 50;
  localparam int RST   = 10;
  localparam int FRAME = 40;
  localparam int SLACK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  usb_host_presence_monitor_if #(.SKIP_CNT_W(8)) bus ();

  usb_host_presence_monitor #(
    .PRESENCE_TIMEOUT_CYCLES(PRES),
    .SUSPEND_CYCLES         (SUSP),
    .BUS_RESET_CYCLES       (RST),
    .FRAME_CYCLES           (FRAME),
    .SOF_SLACK_CYCLES       (SLACK),
    .SKIP_CNT_W             (8)
  ) dut (
    .clk_48mhz(clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bus state described by run lengths and time since the last SOF.
  int       edge_cnt = 0;
  int       last_sof = 0;
  int       se0_run = 0;
  int       j_run = 0;
  int       m_fault = 0;
  int       age;
  bit       m_present = 0, m_susp = 0, m_timeout = 0, m_resume = 0;
  bit       m_missed = 0, m_skip = 0, have_prev = 0;
  bit       br_old, pres_old, susp_old, is_j, is_se0, sof, tx, entry;
  logic [10:0] prev = '0;
  logic [1:0]  h1 = 2'b10, h2 = 2'b10, line;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 = 2'b10; h2 = 2'b10;
      se0_run = 0; j_run = 0; m_fault = 0; last_sof = edge_cnt;
      m_present = 0; m_susp = 0; m_timeout = 0; m_resume = 0;
      m_missed = 0; m_skip = 0; have_prev = 0; prev = '0;
    end else begin
      edge_cnt++;
      br_old   = (se0_run >= RST);
      pres_old = m_present;
      susp_old = m_susp;
      line = h2; h2 = h1; h1 = {bus.usb_p_rx, bus.usb_n_rx};
      sof  = bus.sof_valid;
      tx   = bus.usb_tx_en;
      is_j   = (line == 2'b10);
      is_se0 = (line == 2'b00);
      se0_run = (is_se0 && !tx) ? se0_run + 1 : 0;
      j_run   = (is_j && !tx && !sof) ? j_run + 1 : 0;
      age = edge_cnt - last_sof;
      m_timeout = pres_old && !sof && !br_old && (age == PRES);
      m_missed  = !sof && pres_old && !susp_old && (age >= FRAME + SLACK) &&
                  ((age - FRAME - SLACK) % FRAME == 0);
      m_skip    = sof && have_prev && (int'(bus.frame_index) != (int'(prev) + 1) % 2048);
      m_resume  = susp_old && (!is_j || br_old);
      entry     = !susp_old && (j_run >= SUSP);
      if (m_resume) m_susp = 0;
      else if (entry) m_susp = 1;
      if (br_old) m_present = 0;
      else if (sof) m_present = 1;
      else if (m_timeout) m_present = 0;
      if (br_old || entry || m_timeout) have_prev = 0;
      else if (sof) have_prev = 1;
      if (sof) begin
        prev = bus.frame_index;
        last_sof = edge_cnt;
      end
      if (br_old) m_fault = 0;
      else if ((m_missed || m_skip) && m_fault < 255) m_fault++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("host_present", bus.host_present, m_present);
      check("host_timeout", bus.host_timeout, m_timeout);
      check("suspended",    bus.suspended,    m_susp);
      check("resume",       bus.resume,       m_resume);
      check("bus_reset",    bus.bus_reset,    se0_run >= RST);
      check("sof_missed",   bus.sof_missed,   m_missed);
      check("frame_skip",   bus.frame_skip,   m_skip);
      check("fault_count",  bus.fault_count,  m_fault);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sof(input int idx);
    bus.sof_valid   = 1'b1;
    bus.frame_index = idx[10:0];
    @(negedge clk);
    bus.sof_valid   = 1'b0;
  endtask

  task automatic drive_line(input logic p, input logic n);
    bus.usb_p_rx = p;
    bus.usb_n_rx = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_line(1'b1, 1'b0);
    bus.usb_tx_en   = 1'b1;
    bus.sof_valid   = 1'b0;
    bus.frame_index = '0;
    #12;
    check("rst_host_present", bus.host_present, 0);
    check("rst_suspended",    bus.suspended,    0);
    check("rst_bus_reset",    bus.bus_reset,    0);
    check("rst_fault_count",  bus.fault_count,  0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Presence and timeout.
    send_sof(5);
    check("t1_present_after_sof", bus.host_present, 1);
    idle(199);
    check("t1_present_199", bus.host_present, 1);
    check("t1_timeout_199", bus.host_timeout, 0);
    idle(1);
    check("t1_present_200", bus.host_present, 0);
    check("t1_timeout_200", bus.host_timeout, 1);
    check("t1_fault_4miss", bus.fault_count, 4);
    idle(1);
    check("t1_timeout_once", bus.host_timeout, 0);

    // Bus reset to clear the fault count.
    bus.usb_tx_en = 1'b0;
    drive_line(1'b0, 1'b0);
    idle(15);
    check("clr_bus_reset_hi", bus.bus_reset, 1);
    check("clr_fault", bus.fault_count, 0);
    drive_line(1'b1, 1'b0);
    idle(3);
    check("clr_bus_reset_lo", bus.bus_reset, 0);
    bus.usb_tx_en = 1'b1;

    // Frame continuity across the 2047 -> 0 wrap, then a skip.
    send_sof(2046);
    check("t2_skip_2046", bus.frame_skip, 0);
    idle(39);
    send_sof(2047);
    check("t2_skip_2047", bus.frame_skip, 0);
    idle(39);
    send_sof(0);
    check("t2_skip_0", bus.frame_skip, 0);
    idle(39);
    send_sof(1);
    check("t2_skip_1", bus.frame_skip, 0);
    check("t2_fault_0", bus.fault_count, 0);
    idle(39);
    send_sof(5);
    check("t2_skip_5", bus.frame_skip, 1);
    check("t2_fault_1", bus.fault_count, 1);
    idle(1);
    check("t2_skip_pulse", bus.frame_skip, 0);

    // Short SE0 (EOP-like) versus a real bus reset.
    check("t4_present_before", bus.host_present, 1);
    bus.usb_tx_en = 1'b0;
    drive_line(1'b0, 1'b0);
    idle(4);
    drive_line(1'b1, 1'b0);
    idle(3);
    check("t4_eop_no_reset", bus.bus_reset, 0);
    check("t4_eop_present", bus.host_present, 1);
    drive_line(1'b0, 1'b0);
    idle(15);
    check("t4_bus_reset_hi", bus.bus_reset, 1);
    check("t4_present_clr", bus.host_present, 0);
    check("t4_fault_clr", bus.fault_count, 0);
    drive_line(1'b1, 1'b0);
    idle(3);
    check("t4_bus_reset_lo", bus.bus_reset, 0);
    bus.usb_tx_en = 1'b1;

    // Missed SOF windows.
    send_sof(9);
    idle(43);
    check("t3_miss_43", bus.sof_missed, 0);
    idle(1);
    check("t3_miss_44", bus.sof_missed, 1);
    check("t3_fault_1", bus.fault_count, 1);
    idle(40);
    check("t3_miss_84", bus.sof_missed, 1);
    check("t3_fault_2", bus.fault_count, 2);
    idle(40);
    check("t3_miss_124", bus.sof_missed, 1);
    check("t3_fault_3", bus.fault_count, 3);
    idle(1);
    check("t3_miss_pulse", bus.sof_missed, 0);
    idle(5);

    // Suspend and resume.
    bus.usb_tx_en = 1'b0;
    idle(49);
    check("t5_susp_49", bus.suspended, 0);
    idle(1);
    check("t5_susp_50", bus.suspended, 1);
    drive_line(1'b0, 1'b1);
    idle(2);
    check("t5_susp_k_sync", bus.suspended, 1);
    idle(1);
    check("t5_resume", bus.resume, 1);
    check("t5_awake", bus.suspended, 0);
    idle(1);
    check("t5_resume_pulse", bus.resume, 0);
    bus.usb_tx_en = 1'b1;
    drive_line(1'b1, 1'b0);
    idle(60);
    check("t5_tx_no_susp", bus.suspended, 0);

    // Asynchronous reset while suspended with a host present.
    send_sof(20);
    bus.usb_tx_en = 1'b0;
    idle(55);
    check("t6_susp", bus.suspended, 1);
    check("t6_present", bus.host_present, 1);
    check("t6_fault_5", bus.fault_count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_present", bus.host_present, 0);
    check("t6_async_susp",    bus.suspended,    0);
    check("t6_async_fault",   bus.fault_count,  0);
    check("t6_async_missed",  bus.sof_missed,   0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.usb_tx_en = 1'b1;
    idle(2);
    send_sof(21);
    check("t6_first_sof_skip", bus.frame_skip, 0);
    check("t6_present_again", bus.host_present, 1);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
